// File: rtl/risc_cpu_sys.sv
// Eight-phase accumulator CPU: two-byte fetch, decode, execute, internal 1Kx8 RAM
// at 1800h-1FFFh, external ROM elsewhere.
`timescale 1ns/1ps
module risc_cpu_sys (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rom_data,
  output logic [12:0] addr,
  output logic        rd,
  output logic        wr,
  output logic        rom_sel,
  output logic        ram_sel,
  output logic [7:0]  data,
  output logic        halt,
  output logic        fetch,
  output logic [2:0]  opcode,
  output logic [12:0] ir_addr,
  output logic [12:0] pc_addr
);

  // state | meaning
  // S0    | fetch high instruction byte, PC+1
  // S1    | fetch low instruction byte, PC+1
  // S2-S3 | decode
  // S4    | operand address out; HLT freezes here
  // S5    | execute: ALU load, STO write, JMP, SKZ
  // S6-S7 | idle tail, operand address held
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t      state, state_nx;
  logic [12:0] pc, pc_nx;
  logic [7:0]  acc, acc_nx;
  logic [15:0] ir, ir_nx;
  logic        halt_nx;
  logic [2:0]  op;
  logic        alu_op;
  logic [12:0] addr_int;
  logic        rd_int;
  logic        wr_int;
  logic [7:0]  ram [1024];
  logic [7:0]  ram_q;

  assign op     = ir[15:13];
  assign alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

  always_comb begin
    addr_int = pc;
    rd_int   = 1'b0;
    wr_int   = 1'b0;
    case (state)
      S0, S1: rd_int = 1'b1;
      S4: begin
        addr_int = ir[12:0];
        rd_int   = alu_op;
      end
      S5: begin
        addr_int = ir[12:0];
        rd_int   = alu_op;
        wr_int   = (op == OP_STO);
      end
      S6, S7: addr_int = ir[12:0];
      default: ;
    endcase
  end

  // Reset gates the strobes combinationally so an aborted STO cannot write.
  assign addr    = reset ? 13'h0000 : addr_int;
  assign rd      = rd_int & ~reset;
  assign wr      = wr_int & ~reset;
  assign ram_sel = (addr[12:11] == 2'b11);
  assign rom_sel = ~ram_sel;
  assign ram_q   = ram[addr[9:0]];

  always_comb begin
    if (rd && rom_sel)      data = rom_data;
    else if (rd && ram_sel) data = ram_q;
    else if (wr)            data = acc;
    else                    data = 8'h00;
  end

  assign fetch   = reset | ~state[2];
  assign opcode  = reset ? 3'b000 : op;
  assign ir_addr = ir[12:0];
  assign pc_addr = pc;

  always_comb begin
    state_nx = state_t'(state + 3'd1);
    pc_nx    = pc;
    acc_nx   = acc;
    ir_nx    = ir;
    halt_nx  = halt;
    case (state)
      S0: begin
        ir_nx[15:8] = data;
        pc_nx       = pc + 13'd1;
      end
      S1: begin
        ir_nx[7:0] = data;
        pc_nx      = pc + 13'd1;
      end
      S4: begin
        if (op == OP_HLT) begin
          halt_nx  = 1'b1;
          state_nx = S4;
        end
      end
      S5: begin
        case (op)
          OP_ADD: acc_nx = acc + data;
          OP_AND: acc_nx = acc & data;
          OP_XOR: acc_nx = acc ^ data;
          OP_LDA: acc_nx = data;
          OP_JMP: pc_nx  = ir[12:0];
          OP_SKZ: if (acc == 8'h00) pc_nx = pc + 13'd2;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      pc    <= 13'h0000;
      acc   <= 8'h00;
      ir    <= 16'h0000;
      halt  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      acc   <= acc_nx;
      ir    <= ir_nx;
      halt  <= halt_nx;
    end
  end

  // RAM has no reset so its contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (wr && ram_sel) ram[addr[9:0]] <= data;
  end

endmodule

// File: tb/tb_risc_cpu_sys.sv
// Directed programs run from a bench-side ROM; stores are logged off the bus.
`timescale 1ns/1ps
module tb_risc_cpu_sys;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic        clk, reset;
  logic [7:0]  rom_data;
  logic [12:0] addr, ir_addr, pc_addr;
  logic        rd, wr, rom_sel, ram_sel, halt, fetch;
  logic [7:0]  data;
  logic [2:0]  opcode;

  logic [7:0]  rom [8192];
  int          checks = 0, passes = 0, cyc = 0;
  bit          both_high = 0, sel_bad = 0;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
    logic        rs;
    logic        ms;
  } wr_t;
  wr_t wlog[$];

  risc_cpu_sys dut (
    .clk(clk), .reset(reset), .rom_data(rom_data), .addr(addr), .rd(rd), .wr(wr),
    .rom_sel(rom_sel), .ram_sel(ram_sel), .data(data), .halt(halt), .fetch(fetch),
    .opcode(opcode), .ir_addr(ir_addr), .pc_addr(pc_addr)
  );

  assign rom_data = rom[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd && wr) both_high = 1;
    if (rom_sel === ram_sel) sel_bad = 1;
    if (!reset && wr) wlog.push_back('{addr, data, rom_sel, ram_sel});
  end

  task automatic clear_rom();
    for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
  endtask

  task automatic put(input int idx, input logic [2:0] op, input logic [12:0] a);
    rom[2*idx]   = {op, a[12:8]};
    rom[2*idx+1] = a[7:0];
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to_halt(input int budget, input string name);
    int n;
    n = 0;
    while (halt !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (halt !== 1'b1) $display("FAIL %s_halt halt=%b after %0d cycles, expected 1", name, halt, n);
    else passes++;
  endtask

  task automatic pad_log(input int n);
    while (wlog.size() < n) wlog.push_back('{13'h0, 8'h0, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    clear_rom();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd, wr, fetch, halt} !== 4'b0010) $display("FAIL reset_strobes rd/wr/fetch/halt=%b expected 0010", {rd, wr, fetch, halt});
    else passes++;
    checks++;
    if (addr !== 13'h0000 || pc_addr !== 13'h0000) $display("FAIL reset_addr addr=%h pc=%h expected 0000", addr, pc_addr);
    else passes++;
    checks++;
    if (opcode !== 3'b000 || data !== 8'h00) $display("FAIL reset_bus opcode=%b data=%h expected 000/00", opcode, data);
    else passes++;
    checks++;
    if (rom_sel !== 1'b1 || ram_sel !== 1'b0) $display("FAIL reset_sel rom=%b ram=%b expected 1/0", rom_sel, ram_sel);
    else passes++;
  endtask

  task automatic test_basic();
    clear_rom();
    rom[13'h800] = 8'h05;
    rom[13'h801] = 8'h07;
    put(0, LDA, 13'h0800); put(1, STO, 13'h1800); put(2, LDA, 13'h0801); put(3, STO, 13'h1801); put(4, HLT, 13'h0);
    pulse_reset();
    run_to_halt(200, "preload");
    clear_rom();
    put(0, LDA, 13'h1800); put(1, ADD, 13'h1801); put(2, STO, 13'h1802); put(3, HLT, 13'h0);
    wlog.delete();
    pulse_reset();
    for (int n = 1; n <= 29; n++) begin
      step();
      if (n == 1) begin
        checks++;
        if (pc_addr !== 13'd1 || fetch !== 1'b1) $display("FAIL basic_s1 pc=%h fetch=%b expected 0001/1", pc_addr, fetch);
        else passes++;
      end
      if (n == 28) begin
        checks++;
        if (halt !== 1'b0 || fetch !== 1'b0) $display("FAIL basic_c28 halt=%b fetch=%b expected 0/0", halt, fetch);
        else passes++;
      end
      if (n == 29) begin
        checks++;
        if (halt !== 1'b1) $display("FAIL basic_c29 halt=%b expected 1", halt);
        else passes++;
      end
    end
    for (int n = 0; n < 10; n++) step();
    checks++;
    if (halt !== 1'b1 || pc_addr !== 13'h0008 || fetch !== 1'b0) $display("FAIL basic_frozen halt=%b pc=%h fetch=%b expected 1/0008/0", halt, pc_addr, fetch);
    else passes++;
    checks++;
    if (wlog.size() != 1) $display("FAIL basic_nwr writes=%0d expected 1", wlog.size());
    else passes++;
    pad_log(1);
    checks++;
    if (wlog[0].a !== 13'h1802 || wlog[0].d !== 8'h0C || wlog[0].ms !== 1'b1) $display("FAIL basic_sum addr=%h data=%h ram_sel=%b expected 1802/0c/1", wlog[0].a, wlog[0].d, wlog[0].ms);
    else passes++;
  endtask

  task automatic test_skz();
    for (int v = 0; v < 2; v++) begin
      clear_rom();
      rom[13'h800] = 8'(v);
      put(0, LDA, 13'h0800); put(1, SKZ, 13'h0); put(2, JMP, 13'h0010); put(3, HLT, 13'h0);
      pulse_reset();
      while (cyc < 14) step();
      checks++;
      if (pc_addr !== (v == 0 ? 13'h0006 : 13'h0004)) $display("FAIL skz%0d_pc pc=%h expected %h", v, pc_addr, (v == 0 ? 13'h0006 : 13'h0004));
      else passes++;
      if (v == 1) begin
        while (cyc < 22) step();
        checks++;
        if (pc_addr !== 13'h0010) $display("FAIL skz1_jmp pc=%h expected 0010", pc_addr);
        else passes++;
      end
      run_to_halt(100, "skz");
      checks++;
      if (pc_addr !== (v == 0 ? 13'h0008 : 13'h0012)) $display("FAIL skz%0d_end pc=%h expected %h", v, pc_addr, (v == 0 ? 13'h0008 : 13'h0012));
      else passes++;
    end
  endtask

  task automatic test_alu();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h30; exp_d[1] = 8'hCF; exp_d[2] = 8'h00;
    clear_rom();
    rom[13'h800] = 8'hF0; rom[13'h801] = 8'h3C; rom[13'h802] = 8'hFF;
    rom[13'h803] = 8'hFF; rom[13'h804] = 8'h01;
    put(0, LDA, 13'h0800); put(1, AND_, 13'h0801); put(2, STO, 13'h0000); put(3, XOR_, 13'h0802);
    put(4, STO, 13'h0000); put(5, LDA, 13'h0803); put(6, ADD, 13'h0804); put(7, STO, 13'h0000);
    put(8, SKZ, 13'h0); put(9, STO, 13'h0001); put(10, HLT, 13'h0);
    wlog.delete();
    pulse_reset();
    run_to_halt(200, "alu");
    checks++;
    if (wlog.size() != 3 || pc_addr !== 13'h0016) $display("FAIL alu_flow writes=%0d pc=%h expected 3/0016", wlog.size(), pc_addr);
    else passes++;
    pad_log(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wlog[i].d !== exp_d[i] || wlog[i].rs !== 1'b1) $display("FAIL alu_res%0d data=%h rom_sel=%b expected %h/1", i, wlog[i].d, wlog[i].rs, exp_d[i]);
      else passes++;
    end
  endtask

  task automatic test_sto_rom();
    clear_rom();
    rom[13'h800] = 8'hAA; rom[13'h801] = 8'h55;
    put(0, LDA, 13'h0800); put(1, STO, 13'h1900); put(2, LDA, 13'h0801); put(3, STO, 13'h0100);
    put(4, LDA, 13'h1900); put(5, STO, 13'h0000); put(6, HLT, 13'h0);
    wlog.delete();
    pulse_reset();
    run_to_halt(200, "sto_rom");
    pad_log(3);
    checks++;
    if (wlog[1].a !== 13'h0100 || wlog[1].d !== 8'h55 || wlog[1].rs !== 1'b1 || wlog[1].ms !== 1'b0)
      $display("FAIL sto_rom_bus addr=%h data=%h rom=%b ram=%b expected 0100/55/1/0", wlog[1].a, wlog[1].d, wlog[1].rs, wlog[1].ms);
    else passes++;
    checks++;
    if (wlog[2].d !== 8'hAA) $display("FAIL sto_rom_ram readback=%h expected aa", wlog[2].d);
    else passes++;
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[13'h800] = 8'h11; rom[13'h801] = 8'h22;
    put(0, LDA, 13'h0800); put(1, STO, 13'h1805); put(2, LDA, 13'h0801); put(3, STO, 13'h1805); put(4, HLT, 13'h0);
    pulse_reset();
    while (cyc < 29) step();
    checks++;
    if (wr !== 1'b1) $display("FAIL rmid_s5 wr=%b expected 1", wr);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({rd, wr, fetch} !== 3'b001 || addr !== 13'h0000 || data !== 8'h00)
      $display("FAIL rmid_gate rd/wr/fetch=%b addr=%h data=%h expected 001/0000/00", {rd, wr, fetch}, addr, data);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc_addr !== 13'h0000 || opcode !== 3'b000) $display("FAIL rmid_pc pc=%h opcode=%b expected 0000/000", pc_addr, opcode);
    else passes++;
    clear_rom();
    put(0, LDA, 13'h1805); put(1, STO, 13'h0000); put(2, HLT, 13'h0);
    wlog.delete();
    reset = 1'b0;
    cyc = 0;
    #1;
    checks++;
    if (rd !== 1'b1 || addr !== 13'h0000 || fetch !== 1'b1) $display("FAIL rmid_first rd=%b addr=%h fetch=%b expected 1/0000/1", rd, addr, fetch);
    else passes++;
    run_to_halt(100, "rmid");
    pad_log(1);
    checks++;
    if (wlog[0].d !== 8'h11) $display("FAIL rmid_ram readback=%h expected 11", wlog[0].d);
    else passes++;
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    put(0, LDA, 13'h0800); put(1, STO, 13'h1FFE); put(2, STO, 13'h1FFF); put(3, JMP, 13'h1FFE);
    pulse_reset();
    run_to_halt(200, "wrap");
    checks++;
    if (pc_addr !== 13'h0000) $display("FAIL wrap_pc pc=%h expected 0000", pc_addr);
    else passes++;
  endtask

  task automatic test_fib();
    int exp_f [14];
    int seen [$];
    exp_f = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    clear_rom();
    rom[13'h800] = 8'h00; rom[13'h801] = 8'h01; rom[13'h802] = 8'hF2;
    put(0, LDA, 13'h0800); put(1, STO, 13'h1800); put(2, LDA, 13'h0801);
    put(3, STO, 13'h1801); put(4, LDA, 13'h0802); put(5, STO, 13'h1804);
    put(6, LDA, 13'h1800); put(7, STO, 13'h1802); put(8, ADD, 13'h1801); put(9, STO, 13'h1803);
    put(10, LDA, 13'h1801); put(11, STO, 13'h1800); put(12, LDA, 13'h1803); put(13, STO, 13'h1801);
    put(14, LDA, 13'h1804); put(15, ADD, 13'h0801); put(16, STO, 13'h1804);
    put(17, SKZ, 13'h0); put(18, JMP, 13'h000C); put(19, HLT, 13'h0);
    wlog.delete();
    pulse_reset();
    run_to_halt(4000, "fib");
    foreach (wlog[i]) if (wlog[i].a == 13'h1802) seen.push_back(int'(wlog[i].d));
    checks++;
    if (seen.size() != 14) $display("FAIL fib_count stores=%0d expected 14", seen.size());
    else passes++;
    while (seen.size() < 14) seen.push_back(-1);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (seen[i] != exp_f[i]) $display("FAIL fib_%0d got=%0d expected %0d", i, seen[i], exp_f[i]);
      else passes++;
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (both_high) $display("FAIL rd_wr_overlap seen=%b expected 0", both_high);
    else passes++;
    checks++;
    if (sel_bad) $display("FAIL select_onehot seen=%b expected 0", sel_bad);
    else passes++;
  endtask

  initial begin
    reset = 1'b1;
    clear_rom();
    test_reset();
    test_basic();
    test_skz();
    test_alu();
    test_sto_rom();
    test_reset_mid();
    test_pc_wrap();
    test_fib();
    test_bus_rules();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
